// File: rtl/product_accumulator.sv
// product_accumulator: sums blocks of multiplier products and hands each block sum downstream over valid/ready.
//   Optional saturation: define PRODUCT_ACCUMULATOR_SAT_EN to clamp the sum to all-ones on overflow.
//   Ports: clk, rst (sync, active-high), clear (sync abort)
//          prod_in/prod_valid/prod_ready/last_in  - product stream in
//          acc_out/acc_count/overflow/acc_valid/acc_ready - block result out
module product_accumulator #(
  parameter int PROD_W    = 64,
  parameter int ACC_W     = 72,
  parameter int BLOCK_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic              last_in,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [7:0]        acc_count,
  output logic              overflow
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_out_q, acc_out_d, beat_acc;
  logic [7:0]       cnt_q, cnt_d, acc_count_q, acc_count_d, cnt_inc;
  logic             ovf_q, ovf_d, overflow_q, overflow_d;
  logic [ACC_W:0]   sum;
  logic             carry, accept, block_end;
  assign prod_ready = state_q == ACCUM && !clear && !rst;
  assign acc_valid  = state_q == HOLD;
  assign acc_out    = acc_out_q;
  assign acc_count  = acc_count_q;
  assign overflow   = overflow_q;
  always_comb begin
    sum       = {1'b0, acc_q} + (ACC_W+1)'(prod_in);
    carry     = sum[ACC_W];
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    // once a carry has been seen the sum is pinned at all-ones for the rest of the block
    beat_acc  = (carry || ovf_q) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    beat_acc  = sum[ACC_W-1:0];
`endif
    cnt_inc   = cnt_q + 8'd1;
    accept    = prod_valid && prod_ready;
    block_end = accept && (cnt_inc == 8'(BLOCK_LEN) || last_in);
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    acc_out_d   = acc_out_q;
    acc_count_d = acc_count_q;
    overflow_d  = overflow_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (block_end) begin
      acc_out_d   = beat_acc;
      acc_count_d = cnt_inc;
      overflow_d  = ovf_q || carry;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      state_d     = HOLD;
    end else if (accept) begin
      acc_d = beat_acc;
      cnt_d = cnt_inc;
      ovf_d = ovf_q || carry;
    end else if (acc_valid && acc_ready) begin
      state_d = ACCUM;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      acc_out_q   <= '0;
      acc_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      acc_out_q   <= acc_out_d;
      acc_count_q <= acc_count_d;
      overflow_q  <= overflow_d;
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed and random checks of two accumulator widths against a block-sum model.
module tb_product_accumulator;
  localparam int BL = 8;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic        clk = 1'b0, rst, clear, prod_valid, last_in, acc_ready;
  logic [63:0] prod_in;
  logic        ready_a, valid_a, ovf_a, ready_b, valid_b, ovf_b;
  logic [71:0] out_a;
  logic [63:0] out_b;
  logic [7:0]  cnt_a, cnt_b;
  bit           mst;
  logic [127:0] msum;
  int           mcnt;
  logic [71:0]  e_a;
  logic [63:0]  e_b;
  logic [7:0]   e_cnt;
  bit           e_oa, e_ob;
  int           tests = 0, fails = 0;
  logic [71:0]  held;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(64), .ACC_W(72), .BLOCK_LEN(BL)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(ready_a), .last_in(last_in), .acc_out(out_a), .acc_valid(valid_a),
    .acc_ready(acc_ready), .acc_count(cnt_a), .overflow(ovf_a));

  product_accumulator #(.PROD_W(64), .ACC_W(64), .BLOCK_LEN(BL)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(ready_b), .last_in(last_in), .acc_out(out_b), .acc_valid(valid_b),
    .acc_ready(acc_ready), .acc_count(cnt_b), .overflow(ovf_b));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // one clock: drive inputs, check the combinational ready, advance the block-sum model, check registered outputs
  task automatic cyc(input bit v, input logic [63:0] p, input bit l, input bit r, input bit c, input bit rs);
    prod_valid = v; prod_in = p; last_in = l; acc_ready = r; clear = c; rst = rs;
    #1;
    chk("prod_ready_a", ready_a, !rs && !c && !mst);
    chk("prod_ready_b", ready_b, !rs && !c && !mst);
    @(posedge clk); #1;
    if (rs) begin
      mst = 0; msum = 0; mcnt = 0; e_a = 0; e_b = 0; e_cnt = 0; e_oa = 0; e_ob = 0;
    end else if (c) begin
      mst = 0; msum = 0; mcnt = 0;
    end else if (mst) begin
      if (r) mst = 0;
    end else if (v) begin
      msum = msum + 128'(p);
      mcnt++;
      if (mcnt == BL || l) begin
        e_oa  = |msum[127:72];
        e_ob  = |msum[127:64];
        e_a   = (SAT && e_oa) ? {72{1'b1}} : msum[71:0];
        e_b   = (SAT && e_ob) ? {64{1'b1}} : msum[63:0];
        e_cnt = 8'(mcnt);
        msum = 0; mcnt = 0; mst = 1;
      end
    end
    chk("acc_valid_a", valid_a, mst);
    chk("acc_valid_b", valid_b, mst);
    chk("acc_out_a", out_a, e_a);
    chk("acc_count_a", cnt_a, e_cnt);
    chk("overflow_a", ovf_a, e_oa);
    chk("acc_out_b", out_b, e_b);
    chk("acc_count_b", cnt_b, e_cnt);
    chk("overflow_b", ovf_b, e_ob);
  endtask

  initial begin
    mst = 0; msum = 0; mcnt = 0; e_a = 0; e_b = 0; e_cnt = 0; e_oa = 0; e_ob = 0;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) cyc(1, 64'(i), 0, 1, 0, 0);
    chk("sum36", out_a, 72'd36);
    chk("count8", cnt_a, 8'd8);
    cyc(1, 64'd100, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 64'hFFFF_FFFE_0000_0001, i == 2, 0, 0, 0);
    chk("sq_sum", out_a, 72'h2_FFFF_FFFA_0000_0003);
    chk("sq_count", cnt_a, 8'd3);
    held = out_a;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 64'd99, 0, 0, 0, 0);
      chk("hold_stable", out_a, held);
    end
    cyc(1, 64'd99, 0, 1, 0, 0);
    cyc(1, 64'd5, 1, 1, 0, 0);
    chk("fresh_sum", out_a, 72'd5);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 64'd10, 0, 0, 0, 0);
    cyc(1, 64'd10, 0, 0, 1, 0);
    cyc(1, 64'd3, 0, 0, 0, 0);
    cyc(1, 64'd4, 1, 0, 0, 0);
    cyc(1, 64'd0, 0, 1, 1, 0);
    chk("clear_drop", valid_a, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1, 64'd1, 0, 0, 0, 0);
    chk("after_clear", out_a, 72'd8);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
    cyc(1, 64'd2, 1, 0, 0, 0);
    chk("ovf_out_b", out_b, SAT ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd1);
    chk("ovf_flag_b", ovf_b, 1'b1);
    chk("wide_no_ovf", out_a, 72'h1_0000_0000_0000_0001);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 64'd7, 0, 0, 0, 0);
    cyc(1, 64'd7, 0, 0, 0, 1);
    chk("rst_out", out_a, 72'd0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 64'd9, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_hold", valid_a, 1'b0);
    cyc(1, 64'd1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [63:0] p;
      p = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) p = 64'(p[7:0]);
      cyc($urandom_range(0, 3) != 0, p, $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
